fibonacci_checker: RTL and testbench
====================================

// Module: fibonacci_checker
// PURPOSE
//  Receive-side counterpart to the Fibonacci generator. Consumes a stream of terms
//  (e.g. the generator's fib_out) and checks it against the sequence 0,1,1,2,3,5,...
//  Reports per-term match/mismatch, a sticky error, a term count and completion.
//  Sits beside the generator in self-checking benches and on-chip BIST paths.
// PARAMETERS
//  WIDTH      32  data width of in_data / exp_data
//  MAX_TERMS  48  terms checked before DONE (F(0)..F(47); F(47)=2971215073 is the last 32-bit term)
//  CNT_W      8   width of term_cnt; must hold MAX_TERMS
// PORTS
//  clk        in   1        rising-edge clock
//  rst        in   1        synchronous, active-low reset (rst==0 resets on the clock edge)
//  start      in   1        1-cycle pulse: (re)arm the checker at F(0)
//  in_valid   in   1        in_data carries a term this cycle
//  in_data    in   WIDTH    received term
//  in_ready   out  1        1 while in CHECK; terms are only consumed when in_valid & in_ready
//  exp_data   out  WIDTH    term currently expected
//  match      out  1        1-cycle pulse: last consumed term was correct
//  mismatch   out  1        1-cycle pulse: last consumed term was wrong
//  err        out  1        sticky error; cleared only by start or reset
//  term_cnt   out  CNT_W    number of correct terms consumed since start
//  done       out  1        level: all required terms were checked without error
// BEHAVIOUR
//  Reset (rst==0 at a clk edge): state=IDLE, exp_data=0, next term=1, nxt_ovf=0,
//   match=0, mismatch=0, err=0, term_cnt=0, done=0, in_ready=0.
//  Internal regs: a (=exp_data), b (next term), nxt_ovf (b does not fit in WIDTH bits).
//  FSM states: IDLE, CHECK, DONE, ERROR.
//   IDLE:  wait for start. in_valid is ignored.
//   start in any state: next state=CHECK; a=0, b=1, nxt_ovf=0, term_cnt=0, err=0, done=0.
//   CHECK on consume (in_valid & in_ready & !start):
//    - in_data==a: match=1 next cycle; a<=b; b<=a+b (truncated to WIDTH);
//      nxt_ovf<=carry out of the (WIDTH+1)-bit sum; term_cnt<=term_cnt+1.
//      Go to DONE if term_cnt+1==MAX_TERMS, or if nxt_ovf was already 1
//      (the next expected term is not representable).
//    - in_data!=a: mismatch=1 next cycle; err<=1; go to ERROR; a, b and term_cnt hold.
//   CHECK with no consume: everything holds; match and mismatch return to 0.
//   DONE:  done=1, in_ready=0; hold until start or reset.
//   ERROR: err=1, in_ready=0; exp_data keeps the term that failed; hold until start or reset.
//  Latency: match, mismatch, err, term_cnt and exp_data update 1 cycle after the consume edge.
//   All outputs are registered except in_ready, which is decoded from state.
//  At most one term is consumed per cycle. Back-to-back valid terms are supported.
//  start together with in_valid: start wins and the term is dropped (not counted, not checked).
//  A start pulse in the middle of CHECK discards all progress and re-arms at F(0).
//  Reset asserted in the middle of an operation: takes priority over start and in_valid.
//  match and mismatch are never both 1. done and err are never both 1.
// TESTING
//  1 Reset, start, then 10 consecutive valid terms 0,1,1,2,3,5,8,13,21,34
//    -> 10 match pulses, term_cnt=10, err=0, exp_data=55.
//  2 After start, feed 0,1,1,2,4 -> mismatch 1 cycle after the 4; err=1;
//    state ERROR; exp_data=3; term_cnt=4; in_ready=0.
//  3 From ERROR, pulse start, then feed 0,1
//    -> err=0, term_cnt=2, exp_data=1.
//  4 WIDTH=32: feed all 48 correct terms F(0)..F(47)=2971215073
//    -> done=1 after the 48th match; term_cnt=48; in_ready=0; further terms ignored.
//  5 Assert start together with in_valid=1, in_data=7
//    -> no match or mismatch; exp_data=0; term_cnt=0.
//  6 With term_cnt=5, assert rst=0 for one cycle
//    -> all outputs return to reset values; state IDLE; following terms ignored until start.

Source files
------------

// File: rtl/fibonacci_checker.sv
// fibonacci_checker
//   Receive-side checker for a Fibonacci term stream (0,1,1,2,3,5,...).
//   Each consumed term is compared against the locally generated expected
//   term. The checker reports per-term match/mismatch pulses, a sticky
//   error, a count of correct terms and a completion level.
// Ports
//   clk       rising-edge clock
//   rst       synchronous active-low reset
//   start     1-cycle pulse, re-arms the checker at F(0)
//   in_valid  in_data carries a term this cycle
//   in_data   received term
//   in_ready  1 while checking; a term is consumed on in_valid & in_ready
//   exp_data  term currently expected
//   match     pulse: last consumed term was correct
//   mismatch  pulse: last consumed term was wrong
//   err       sticky error, cleared by start or reset
//   term_cnt  number of correct terms consumed since start
//   done      level: all required terms checked without error
module fibonacci_checker #(
  parameter int WIDTH     = 32,
  parameter int MAX_TERMS = 48,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic [WIDTH-1:0] exp_data,
  output logic             match,
  output logic             mismatch,
  output logic             err,
  output logic [CNT_W-1:0] term_cnt,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    DONE  = 2'd2,
    ERROR = 2'd3
  } state_t;

  state_t             state, state_n;
  logic [WIDTH-1:0]   a, a_n;
  logic [WIDTH-1:0]   b, b_n;
  logic               nxt_ovf, ovf_n;
  logic [CNT_W-1:0]   cnt_n, cnt_inc;
  logic               match_n, mismatch_n, err_n, done_n;
  logic [WIDTH:0]     sum;

  assign in_ready = (state == CHECK);
  assign exp_data = a;
  assign sum      = {1'b0, a} + {1'b0, b};
  assign cnt_inc  = term_cnt + CNT_W'(1);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      a        <= '0;
      b        <= WIDTH'(1);
      nxt_ovf  <= 1'b0;
      term_cnt <= '0;
      match    <= 1'b0;
      mismatch <= 1'b0;
      err      <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_n;
      a        <= a_n;
      b        <= b_n;
      nxt_ovf  <= ovf_n;
      term_cnt <= cnt_n;
      match    <= match_n;
      mismatch <= mismatch_n;
      err      <= err_n;
      done     <= done_n;
    end
  end

  always_comb begin
    state_n    = state;
    a_n        = a;
    b_n        = b;
    ovf_n      = nxt_ovf;
    cnt_n      = term_cnt;
    match_n    = 1'b0;
    mismatch_n = 1'b0;

    if (start) begin
      // start wins over a simultaneous term, which is dropped unchecked
      state_n = CHECK;
      a_n     = '0;
      b_n     = WIDTH'(1);
      ovf_n   = 1'b0;
      cnt_n   = '0;
    end else begin
      case (state)
        CHECK: begin
          if (in_valid) begin
            if (in_data == a) begin
              match_n = 1'b1;
              a_n     = b;
              b_n     = sum[WIDTH-1:0];
              ovf_n   = sum[WIDTH];
              cnt_n   = cnt_inc;
              // stop when the term budget is reached or the next
              // expected term no longer fits in WIDTH bits
              if (cnt_inc == CNT_W'(MAX_TERMS) || nxt_ovf) begin
                state_n = DONE;
              end
            end else begin
              mismatch_n = 1'b1;
              state_n    = ERROR;
            end
          end
        end
        default: ;
      endcase
    end

    err_n  = (state_n == ERROR);
    done_n = (state_n == DONE);
  end

endmodule

// File: tb/tb_fibonacci_checker.sv
// tb_fibonacci_checker
//   Directed self-checking bench for fibonacci_checker (WIDTH=32,
//   MAX_TERMS=48). Inputs change 1 time unit after a rising edge and
//   outputs are sampled at the same point after the next rising edge.
module tb_fibonacci_checker;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_ready;
  logic [31:0] exp_data;
  logic        match;
  logic        mismatch;
  logic        err;
  logic [7:0]  term_cnt;
  logic        done;

  int unsigned n_checks = 0;
  int unsigned n_fails  = 0;
  longint      fib [0:47];

  fibonacci_checker #(
    .WIDTH    (32),
    .MAX_TERMS(48),
    .CNT_W    (8)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .in_valid(in_valid),
    .in_data (in_data),
    .in_ready(in_ready),
    .exp_data(exp_data),
    .match   (match),
    .mismatch(mismatch),
    .err     (err),
    .term_cnt(term_cnt),
    .done    (done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    in_valid = 1'b0;
    step();
    start = 1'b0;
  endtask

  task automatic feed(input logic [31:0] d);
    in_valid = 1'b1;
    in_data  = d;
    step();
    in_valid = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " exp_data"}, 64'(exp_data), 64'd0);
    chk({tag, " match"},    64'(match),    64'd0);
    chk({tag, " mismatch"}, 64'(mismatch), 64'd0);
    chk({tag, " err"},      64'(err),      64'd0);
    chk({tag, " term_cnt"}, 64'(term_cnt), 64'd0);
    chk({tag, " done"},     64'(done),     64'd0);
    chk({tag, " in_ready"}, 64'(in_ready), 64'd0);
  endtask

  initial begin
    fib[0] = 0;
    fib[1] = 1;
    for (int i = 2; i < 48; i++) fib[i] = fib[i-1] + fib[i-2];

    // reset state
    rst = 1'b0;
    step();
    step();
    chk_reset_vals("reset");
    rst = 1'b1;

    // IDLE ignores terms
    feed(32'd0);
    chk("idle match", 64'(match), 64'd0);
    chk("idle cnt", 64'(term_cnt), 64'd0);
    chk("idle ready", 64'(in_ready), 64'd0);

    // 1: ten correct terms
    pulse_start();
    chk("t1 ready", 64'(in_ready), 64'd1);
    chk("t1 exp0", 64'(exp_data), 64'd0);
    for (int i = 0; i < 10; i++) begin
      feed(fib[i][31:0]);
      chk("t1 match", 64'(match), 64'd1);
      chk("t1 cnt", 64'(term_cnt), 64'(i + 1));
    end
    step();
    chk("t1 match idle", 64'(match), 64'd0);
    chk("t1 exp", 64'(exp_data), 64'd55);
    chk("t1 cnt10", 64'(term_cnt), 64'd10);
    chk("t1 err", 64'(err), 64'd0);

    // 2: wrong fifth term
    pulse_start();
    feed(32'd0); feed(32'd1); feed(32'd1); feed(32'd2);
    feed(32'd4);
    chk("t2 mismatch", 64'(mismatch), 64'd1);
    chk("t2 match", 64'(match), 64'd0);
    chk("t2 err", 64'(err), 64'd1);
    chk("t2 exp", 64'(exp_data), 64'd3);
    chk("t2 cnt", 64'(term_cnt), 64'd4);
    chk("t2 ready", 64'(in_ready), 64'd0);
    feed(32'd3);
    chk("t2 mismatch pulse", 64'(mismatch), 64'd0);
    chk("t2 err sticky", 64'(err), 64'd1);
    chk("t2 done", 64'(done), 64'd0);
    chk("t2 exp hold", 64'(exp_data), 64'd3);

    // 3: restart from ERROR
    pulse_start();
    chk("t3 err clr", 64'(err), 64'd0);
    feed(32'd0); feed(32'd1);
    chk("t3 cnt", 64'(term_cnt), 64'd2);
    chk("t3 exp", 64'(exp_data), 64'd1);
    chk("t3 err", 64'(err), 64'd0);

    // restart in the middle of CHECK discards progress
    pulse_start();
    chk("mid cnt", 64'(term_cnt), 64'd0);
    chk("mid exp", 64'(exp_data), 64'd0);

    // 4: full 48-term run
    for (int i = 0; i < 47; i++) feed(fib[i][31:0]);
    chk("t4 exp47", 64'(exp_data), 64'd2971215073);
    chk("t4 cnt47", 64'(term_cnt), 64'd47);
    chk("t4 not done", 64'(done), 64'd0);
    feed(32'd2971215073);
    chk("t4 match", 64'(match), 64'd1);
    chk("t4 done", 64'(done), 64'd1);
    chk("t4 cnt", 64'(term_cnt), 64'd48);
    chk("t4 ready", 64'(in_ready), 64'd0);
    chk("t4 err", 64'(err), 64'd0);
    feed(32'd0);
    chk("t4 ignore match", 64'(match), 64'd0);
    chk("t4 ignore mismatch", 64'(mismatch), 64'd0);
    chk("t4 ignore cnt", 64'(term_cnt), 64'd48);
    chk("t4 done hold", 64'(done), 64'd1);

    // 5: start with a valid term drops the term
    start = 1'b1; in_valid = 1'b1; in_data = 32'd7;
    step();
    start = 1'b0; in_valid = 1'b0;
    chk("t5 match", 64'(match), 64'd0);
    chk("t5 mismatch", 64'(mismatch), 64'd0);
    chk("t5 exp", 64'(exp_data), 64'd0);
    chk("t5 cnt", 64'(term_cnt), 64'd0);
    chk("t5 done", 64'(done), 64'd0);
    chk("t5 ready", 64'(in_ready), 64'd1);

    // 6: reset mid-run beats start and in_valid
    feed(32'd0); feed(32'd1); feed(32'd1); feed(32'd2); feed(32'd3);
    chk("t6 cnt5", 64'(term_cnt), 64'd5);
    rst = 1'b0; start = 1'b1; in_valid = 1'b1; in_data = 32'd5;
    step();
    rst = 1'b1; start = 1'b0; in_valid = 1'b0;
    chk_reset_vals("t6");
    feed(32'd0);
    chk("t6 ignore match", 64'(match), 64'd0);
    chk("t6 ignore cnt", 64'(term_cnt), 64'd0);
    chk("t6 ignore ready", 64'(in_ready), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
